// File: rtl/clb_cfg_pkg.sv
// Shared types and frame-geometry helpers for the configurable CLB array.
package clb_cfg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_e;

  localparam int LUT_LSB = 0;

  function automatic int frame_w(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int cfg_w(input int n, input int k);
    return n * frame_w(k);
  endfunction

  function automatic int mode_bit(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/clb_cell.sv
// One logic block: K-input LUT lookup plus an optional output flop.
module clb_cell #(
  parameter  int LUT_K = 2,
  localparam int LUT_N = 1 << LUT_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LUT_N-1:0] lut_tbl,
  input  logic             mode,
  input  logic [LUT_K-1:0] lut_in,
  input  logic             clear,
  output logic             cell_out
);

  logic lut_v;
  logic q_d, q_q;

  always_comb begin
    lut_v = lut_tbl[lut_in];
    q_d   = clear ? 1'b0 : lut_v;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign cell_out = mode ? q_q : lut_v;

endmodule

// File: rtl/clb_array_cfg.sv
// N_CLB-cell LUT fabric with a serially loaded, double-buffered configuration
// and an output switch selecting one cell.
module clb_array_cfg
  import clb_cfg_pkg::*;
#(
  parameter  int N_CLB   = 4,
  parameter  int LUT_K   = 2,
  localparam int SEL_W   = $clog2(N_CLB),
  localparam int FRAME_W = frame_w(LUT_K),
  localparam int CFG_W   = cfg_w(N_CLB, LUT_K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  input  logic [N_CLB*LUT_K-1:0] clb_in,
  input  logic [SEL_W-1:0]       sel_clb,
  output logic [N_CLB-1:0]       clb_out,
  output logic                   out
);

  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam int LUT_N = 1 << LUT_K;

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [CFG_W-1:0]   shadow_d, shadow_q;
  logic [CFG_W-1:0]   active_d, active_q;
  logic               cfg_ready_q, cfg_done_q;
  logic               clr_cells;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    clr_cells = 1'b0;
    if (cfg_start) begin
      // A restart always wins, even over a bit offered in the same cycle.
      state_d = LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: if (cfg_valid) begin
          for (int i = 0; i < CFG_W; i++)
            if (cnt_q == CNT_W'(i)) shadow_d[i] = cfg_bit;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CFG_W - 1)) state_d = COMMIT;
        end
        COMMIT: begin
          active_d  = shadow_q;
          cnt_d     = '0;
          clr_cells = 1'b1;
          state_d   = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_ready_q <= (state_d == LOAD);
      cfg_done_q  <= (state_d == DONE);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;

  for (genvar c = 0; c < N_CLB; c++) begin : g_clb
    clb_cell #(.LUT_K(LUT_K)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .lut_tbl  (active_q[c*FRAME_W + LUT_LSB +: LUT_N]),
      .mode     (active_q[c*FRAME_W + mode_bit(LUT_K)]),
      .lut_in   (clb_in[c*LUT_K +: LUT_K]),
      .clear    (clr_cells),
      .cell_out (clb_out[c])
    );
  end

  // Select codes past the last cell read as 0.
  always_comb begin
    out = 1'b0;
    for (int c = 0; c < N_CLB; c++)
      if (sel_clb == SEL_W'(c)) out = clb_out[c];
  end

endmodule

// File: tb/tb_clb_array_cfg.sv
// Scoreboard bench: a 4-CLB and a 3-CLB fabric share one stimulus stream and
// are checked every cycle against a behavioural model of the config protocol.
module tb_clb_array_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic [7:0] clb_in = '0;
  logic [1:0] sel = '0;
  logic       rdy4, dn4, o4, rdy3, dn3, o3;
  logic [3:0] co4;
  logic [2:0] co3;

  clb_array_cfg #(.N_CLB(4), .LUT_K(2)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(rdy4), .cfg_done(dn4), .clb_in(clb_in),
    .sel_clb(sel), .clb_out(co4), .out(o4));

  clb_array_cfg #(.N_CLB(3), .LUT_K(2)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(rdy3), .cfg_done(dn3), .clb_in(clb_in[5:0]),
    .sel_clb(sel), .clb_out(co3), .out(o3));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tid;
    logic [12:0] v;
  } exp_t;

  exp_t expq[$];
  int   total = 0, bad = 0, tid = 0;
  bit   rnd_io = 1'b1;

  // Model state per fabric (index 0: 4 CLBs, 1: 3 CLBs).
  // ph: 0 idle, 1 loading, 2 commit pending, 3 committed.
  int       ph [2];
  bit       ld [2][20];
  int       ldn[2];
  bit [3:0] act_lut [2][4];
  bit       act_mode[2][4];
  bit       qm[2][4];

  localparam logic [4:0] F_XOR  = 5'b00110;
  localparam logic [4:0] F_ANDR = 5'b11000;
  localparam logic [4:0] F_ANDC = 5'b01000;
  localparam logic [4:0] F_ONE  = 5'b01111;

  function automatic int ncl(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  function automatic bit lut_of(input int m, input int c);
    logic [1:0] ix;
    ix = clb_in[2*c +: 2];
    return act_lut[m][c][ix];
  endfunction

  task automatic model_eval(output logic [12:0] e);
    logic [3:0] co [2];
    logic       o  [2];
    for (int m = 0; m < 2; m++) begin
      co[m] = '0;
      for (int c = 0; c < ncl(m); c++)
        co[m][c] = act_mode[m][c] ? qm[m][c] : lut_of(m, c);
      o[m] = (int'(sel) < ncl(m)) ? co[m][sel] : 1'b0;
    end
    e = {co[0], o[0], ph[0] == 1, ph[0] == 3, co[1][2:0], o[1], ph[1] == 1, ph[1] == 3};
  endtask

  task automatic model_step();
    bit l[4];
    bit commit;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 4; c++) l[c] = (c < ncl(m)) ? lut_of(m, c) : 1'b0;
      commit = (ph[m] == 2) && !cfg_start;
      if (rst) begin
        ph[m] = 0; ldn[m] = 0;
        for (int c = 0; c < 4; c++) begin
          act_lut[m][c] = '0; act_mode[m][c] = 1'b0; qm[m][c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < 4; c++) qm[m][c] = commit ? 1'b0 : l[c];
        if (cfg_start) begin
          ph[m] = 1; ldn[m] = 0;
        end else if (ph[m] == 1 && cfg_valid) begin
          ld[m][ldn[m]] = cfg_bit;
          ldn[m]++;
          if (ldn[m] == ncl(m) * 5) ph[m] = 2;
        end else if (ph[m] == 2) begin
          for (int c = 0; c < ncl(m); c++) begin
            for (int j = 0; j < 4; j++) act_lut[m][c][j] = ld[m][c*5 + j];
            act_mode[m][c] = ld[m][c*5 + 4];
          end
          ph[m] = 3;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic b);
    exp_t x;
    rst = r; cfg_start = s; cfg_valid = v; cfg_bit = b;
    if (rnd_io) begin
      clb_in = 8'($urandom);
      sel    = 2'($urandom);
    end
    x.tid = 8'(tid);
    model_eval(x.v);
    expq.push_back(x);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [19:0] s, input bit gaps);
    int   i;
    logic v;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    i = 0;
    while (i < 20) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cyc(1'b0, 1'b0, v, s[i]);
      if (v) i++;
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [12:0] a;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      a = {co4, o4, rdy4, dn4, co3, o3, rdy3, dn3};
      total++;
      if (a !== x.v) begin
        bad++;
        $display("FAIL t%0d outputs got=%b want=%b (co4,o4,rdy4,dn4,co3,o3,rdy3,dn3)",
                 x.tid, a, x.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] s_xor, s_andc, s_mix, s_one, s_rnd;
    s_xor  = {F_XOR, F_XOR, F_XOR, F_XOR};
    s_andc = {F_ANDC, F_ANDC, F_ANDC, F_ANDC};
    s_mix  = {F_XOR, F_ANDR, F_XOR, F_XOR};
    s_one  = {F_ONE, F_ONE, F_ONE, F_ONE};
    @(posedge clk);
    #1;

    // 1: reset with all-ones inputs, every select value
    tid = 1; rnd_io = 1'b0; clb_in = 8'hFF;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    rnd_io = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 2: back-to-back XOR load, then random inputs
    tid = 2; load(s_xor, 1'b0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 3: CLB2 registered AND, directed 00 -> 11 edge
    tid = 3; load(s_mix, 1'b0);
    rnd_io = 1'b0; sel = 2'd2; clb_in = 8'h00;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clb_in = 8'h30;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rnd_io = 1'b1;

    // 4: XOR load with random valid gaps
    tid = 4; load(s_xor, 1'b1);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 5: reload while running, restart at bit 10 drops that bit
    tid = 5;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, s_andc[i]);
    cyc(1'b0, 1'b1, 1'b1, s_andc[10]);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, s_andc[i]);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset in the middle of a load, then out-of-range select on the 3-CLB build
    tid = 6;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, s_xor[i]);
    cyc(1'b1, 1'b0, 1'b1, s_xor[7]);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    load(s_one, 1'b0);
    rnd_io = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    rnd_io = 1'b1;

    // 7: random configurations
    tid = 7;
    repeat (4) begin
      s_rnd = 20'($urandom);
      load(s_rnd, 1'($urandom));
      repeat (10) cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
